// File: rtl/ren_pkg.sv
// Shared types and constants for the result-drain engine: FSM encoding,
// result/byte widths and the signed int8 saturation limits.
package ren_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_PROC = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } ren_state_e;

  localparam int RSLT_W = 20;
  localparam int BYTE_W = 8;

  localparam logic signed [RSLT_W-1:0] SAT_MAX = 20'sd127;
  localparam logic signed [RSLT_W-1:0] SAT_MIN = -20'sd128;

endpackage

// File: rtl/ren_requant.sv
// Requantises one raw accelerator result: sign-extend, arithmetic shift,
// optional ReLU clamp, then saturation to a signed byte.
module ren_requant
  import ren_pkg::*;
(
  input  logic [RSLT_W-1:0] raw_i,
  input  logic [3:0]        shift_i,
  input  logic              relu_en_i,
  output logic [BYTE_W-1:0] byte_o
);

  logic signed [RSLT_W-1:0] shifted_s;
  logic signed [RSLT_W-1:0] clamp_s;

  // shift, clamp and saturate in one combinational pass
  always_comb begin
    shifted_s = $signed(raw_i) >>> shift_i;
    if (relu_en_i && shifted_s[RSLT_W-1]) begin
      clamp_s = '0;
    end else begin
      clamp_s = shifted_s;
    end
    if (clamp_s > SAT_MAX) begin
      byte_o = SAT_MAX[BYTE_W-1:0];
    end else if (clamp_s < SAT_MIN) begin
      byte_o = SAT_MIN[BYTE_W-1:0];
    end else begin
      byte_o = clamp_s[BYTE_W-1:0];
    end
  end

endmodule

// File: rtl/ren_rslt_drain.sv
// Drains accelerator results over a Wishbone classic master: reads each
// 20-bit result, requantises it to int8 and writes packed words to memory.
module ren_rslt_drain
  import ren_pkg::*;
#(
  parameter logic [31:0] ACCEL_RSLT_BASE = 32'h3000_0300,
  parameter int          RSLT_ADDR_WIDTH = 6
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     start,
  input  logic [RSLT_ADDR_WIDTH:0] count,
  input  logic [31:0]              dst_base,
  input  logic [3:0]               shift,
  input  logic                     relu_en,
  output logic                     busy,
  output logic                     done,
  output logic                     wbm_cyc_o,
  output logic                     wbm_stb_o,
  output logic                     wbm_we_o,
  output logic [3:0]               wbm_sel_o,
  output logic [31:0]              wbm_adr_o,
  output logic [31:0]              wbm_dat_o,
  input  logic [31:0]              wbm_dat_i,
  input  logic                     wbm_ack_i
);

  localparam int              IW      = RSLT_ADDR_WIDTH + 1;
  localparam logic [IW-1:0]   MAX_CNT = IW'(1 << RSLT_ADDR_WIDTH);

  ren_state_e          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d, cnt_q, cnt_d;
  logic [31:0]         base_q, base_d, pack_q, pack_d;
  logic [RSLT_W-1:0]   rdat_q, rdat_d;
  logic [3:0]          shift_q, shift_d, lanes_q, lanes_d;
  logic                relu_q, relu_d;
  logic [BYTE_W-1:0]   byte_s;
  logic [IW-1:0]       last_idx_s;
  logic                unused_s;

  assign unused_s   = ^wbm_dat_i[31:RSLT_W];
  assign last_idx_s = idx_q - IW'(1);

  ren_requant u_requant (
    .raw_i     (rdat_q),
    .shift_i   (shift_q),
    .relu_en_i (relu_q),
    .byte_o    (byte_s)
  );

  // state and datapath registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      pack_q  <= '0;
      rdat_q  <= '0;
      shift_q <= '0;
      lanes_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      pack_q  <= pack_d;
      rdat_q  <= rdat_d;
      shift_q <= shift_d;
      lanes_q <= lanes_d;
      relu_q  <= relu_d;
    end
  end

  // next-state and datapath update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    pack_d  = pack_q;
    rdat_d  = rdat_q;
    shift_d = shift_q;
    lanes_d = lanes_q;
    relu_d  = relu_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = (count > MAX_CNT) ? MAX_CNT : count;
          base_d  = dst_base;
          shift_d = shift;
          relu_d  = relu_en;
          idx_d   = '0;
          pack_d  = '0;
          lanes_d = '0;
          state_d = (count == '0) ? ST_FIN : ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (wbm_ack_i) begin
          rdat_d  = wbm_dat_i[RSLT_W-1:0];
          state_d = ST_PROC;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_PROC: begin
        pack_d  = pack_q | (32'(byte_s) << {idx_q[1:0], 3'b000});
        lanes_d = lanes_q | (4'b0001 << idx_q[1:0]);
        idx_d   = idx_q + IW'(1);
        if ((idx_q[1:0] == 2'd3) || (idx_q + IW'(1) == cnt_q)) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_WR: begin
        if (wbm_ack_i) begin
          pack_d  = '0;
          lanes_d = '0;
          state_d = (idx_q < cnt_q) ? ST_RD : ST_FIN;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // bus and status outputs decoded from the current state
  always_comb begin
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = 4'h0;
    wbm_adr_o = 32'h0;
    wbm_dat_o = 32'h0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: busy = 1'b0;
      ST_RD: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = 4'hF;
        wbm_adr_o = ACCEL_RSLT_BASE + (32'(idx_q) << 2);
        busy      = 1'b1;
      end
      ST_PROC: busy = 1'b1;
      ST_WR: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_sel_o = lanes_q;
        wbm_adr_o = base_q + (32'(last_idx_s) & ~32'h3);
        wbm_dat_o = pack_q;
        busy      = 1'b1;
      end
      ST_FIN:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule
